// File: rtl/k12a.inc.sv
// Shared K12A sequencer definitions: state encoding (including STATE_IRQ) and MEM_WAIT limits.
`ifndef K12A_INC_SV
`define K12A_INC_SV

package k12a_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t STATE_FETCH1 = 3'd0;
    localparam state_t STATE_FETCH2 = 3'd1;
    localparam state_t STATE_FETCH3 = 3'd2;
    localparam state_t STATE_EXEC   = 3'd3;
    localparam state_t STATE_HALT   = 3'd4;
    localparam state_t STATE_IRQ    = 3'd5;

    localparam int MEM_WAIT_MIN = 1;
    localparam int MEM_WAIT_MAX = 15;

    function automatic logic mem_wait_legal(input int mem_wait);
        return (mem_wait >= MEM_WAIT_MIN) && (mem_wait <= MEM_WAIT_MAX);
    endfunction

endpackage

`endif

// File: rtl/k12a_wait_counter.sv
// Memory wait-state counter: holds the current state for MEM_WAIT extra cycles per access.
module k12a_wait_counter #(
    parameter int MEM_WAIT = 2,
    parameter int WAIT_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_req,
    output logic              commit,
    output logic              busy_wait,
    output logic [WAIT_W-1:0] wait_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

    // Dropping mem_req mid-access commits at once; the counter clears with it.
    assign commit    = !mem_req || (wait_cnt == WAIT_LAST);
    assign busy_wait = mem_req && !commit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (commit) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/k12a_sequencer.sv
// K12A state sequencer: registered state with memory wait states and optional interrupt entry.
// Interrupt support is compiled in with macro K12A_IRQ_EN.
module k12a_sequencer
    import k12a_sequencer_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int WAIT_W   = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  state_t state_req,
    input  logic   mem_req,
    input  logic   mem_write_req,
    input  logic   irq,
    output state_t state,
    output logic   commit,
    output logic   async_write,
    output logic   irq_ack,
    output logic   busy_wait
);

    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_req_eff;
    state_t            state_req_safe;
    state_t            state_next;

    // STATE_IRQ is only reachable through a pending interrupt, never by direct request.
    assign state_req_safe = (state_req == STATE_IRQ) ? STATE_FETCH1 : state_req;

`ifdef K12A_IRQ_EN
    logic irq_pending;
    logic irq_seen;

    assign irq_seen    = irq_pending || irq;
    assign mem_req_eff = mem_req && (state != STATE_IRQ);
    assign irq_ack     = (state == STATE_IRQ);

    always_comb begin
        state_next = state_req_safe;
        if (state == STATE_IRQ) begin
            state_next = STATE_FETCH1;
        end else if (irq_seen && ((state == STATE_HALT) || (state_req_safe == STATE_FETCH1))) begin
            state_next = STATE_IRQ;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_pending <= 1'b0;
        end else if (state == STATE_IRQ) begin
            irq_pending <= 1'b0;
        end else if (irq) begin
            irq_pending <= 1'b1;
        end
    end
`else
    logic unused_irq;

    assign unused_irq  = irq;
    assign mem_req_eff = mem_req;
    assign irq_ack     = 1'b0;
    assign state_next  = state_req_safe;
`endif

    k12a_wait_counter #(
        .MEM_WAIT(MEM_WAIT),
        .WAIT_W  (WAIT_W)
    ) u_wait (
        .clock    (clock),
        .reset    (reset),
        .mem_req  (mem_req_eff),
        .commit   (commit),
        .busy_wait(busy_wait),
        .wait_cnt (wait_cnt)
    );

    // The first access cycle is address setup, so the strobe starts one cycle late.
    assign async_write = mem_req_eff && mem_write_req && (wait_cnt != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= STATE_FETCH1;
        end else if (commit) begin
            state <= state_next;
        end
    end

endmodule
